// File: rtl/switch_debounce_4.sv
// Four-channel switch debouncer with press/release pulses and per-channel auto-repeat.
// Each raw level is synchronized, debounced by a stability counter, then drives a repeat FSM.
module switch_debounce_4 #(
    parameter int DEBOUNCE_LIMIT = 250000,
    parameter int REPEAT_DELAY   = 12500000,
    parameter int REPEAT_RATE    = 2500000
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_switch_1,
    input  logic i_switch_2,
    input  logic i_switch_3,
    input  logic i_switch_4,
    input  logic i_repeat_en,
    output logic o_switch_1,
    output logic o_switch_2,
    output logic o_switch_3,
    output logic o_switch_4,
    output logic o_press_1,
    output logic o_press_2,
    output logic o_press_3,
    output logic o_press_4,
    output logic o_release_1,
    output logic o_release_2,
    output logic o_release_3,
    output logic o_release_4
);

    localparam int DB_W    = $clog2(DEBOUNCE_LIMIT + 1);
    localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int RPT_W   = $clog2(RPT_MAX + 1);

    localparam logic [DB_W-1:0]  DB_LAST    = DB_W'(DEBOUNCE_LIMIT - 1);
    localparam logic [RPT_W-1:0] DELAY_LAST = RPT_W'(REPEAT_DELAY - 1);
    localparam logic [RPT_W-1:0] RATE_LAST  = RPT_W'(REPEAT_RATE - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DELAY  = 2'd1,
        ST_REPEAT = 2'd2
    } rpt_state_t;

    logic [3:0] w_raw;
    logic [3:0] r_sync1;
    logic [3:0] r_sync2;
    logic [3:0] r_switch;
    logic [3:0] r_press;
    logic [3:0] r_release;

    assign w_raw = {i_switch_4, i_switch_3, i_switch_2, i_switch_1};

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= w_raw;
            r_sync2 <= r_sync1;
        end
    end

    for (genvar g = 0; g < 4; g++) begin : g_chan
        logic [DB_W-1:0]  r_db_cnt;
        logic [RPT_W-1:0] r_rpt_cnt;
        logic [RPT_W-1:0] w_rpt_cnt_next;
        rpt_state_t       r_state;
        rpt_state_t       w_state_next;
        logic             w_diff;
        logic             w_accept;
        logic             w_rise;
        logic             w_fall;
        logic             w_rpt_pulse;

        assign w_diff   = r_sync2[g] != r_switch[g];
        assign w_accept = w_diff && (r_db_cnt == DB_LAST);
        assign w_rise   = w_accept && !r_switch[g];
        assign w_fall   = w_accept && r_switch[g];

        always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
                r_db_cnt     <= '0;
                r_switch[g]  <= 1'b0;
                r_press[g]   <= 1'b0;
                r_release[g] <= 1'b0;
            end else begin
                // Any cycle the synchronized level agrees with the output restarts the count.
                if (!w_diff || w_accept) begin
                    r_db_cnt <= '0;
                end else begin
                    r_db_cnt <= r_db_cnt + 1'b1;
                end
                if (w_accept) begin
                    r_switch[g] <= !r_switch[g];
                end
                r_press[g]   <= w_rise || w_rpt_pulse;
                r_release[g] <= w_fall;
            end
        end

        always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
                r_state   <= ST_IDLE;
                r_rpt_cnt <= '0;
            end else begin
                r_state   <= w_state_next;
                r_rpt_cnt <= w_rpt_cnt_next;
            end
        end

        // NOTE: every output of this block is defaulted first so no path infers a latch.
        always_comb begin
            w_state_next   = r_state;
            w_rpt_cnt_next = r_rpt_cnt;
            w_rpt_pulse    = 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_rise && i_repeat_en) begin
                        w_state_next   = ST_DELAY;
                        w_rpt_cnt_next = '0;
                    end
                end
                ST_DELAY: begin
                    if (w_fall || !i_repeat_en) begin
                        w_state_next = ST_IDLE;
                    end else if (r_rpt_cnt == DELAY_LAST) begin
                        w_rpt_pulse    = 1'b1;
                        w_state_next   = ST_REPEAT;
                        w_rpt_cnt_next = '0;
                    end else begin
                        w_rpt_cnt_next = r_rpt_cnt + 1'b1;
                    end
                end
                ST_REPEAT: begin
                    if (w_fall || !i_repeat_en) begin
                        w_state_next = ST_IDLE;
                    end else if (r_rpt_cnt == RATE_LAST) begin
                        w_rpt_pulse    = 1'b1;
                        w_rpt_cnt_next = '0;
                    end else begin
                        w_rpt_cnt_next = r_rpt_cnt + 1'b1;
                    end
                end
                default: begin
                    w_state_next = ST_IDLE;
                end
            endcase
        end
    end

    assign {o_switch_4, o_switch_3, o_switch_2, o_switch_1}     = r_switch;
    assign {o_press_4, o_press_3, o_press_2, o_press_1}         = r_press;
    assign {o_release_4, o_release_3, o_release_2, o_release_1} = r_release;

endmodule
